// File: rtl/pa_riscv_pkg.sv
// Shared RV32I field types, opcodes and immediate limits for the encoder/loader slice.
package pa_riscv;

   typedef enum logic [1:0] {
      LW         = 2'd0,
      SW         = 2'd1,
      R_TYPE_ALU = 2'd2,
      B_TYPE     = 2'd3
   } e_instrKind;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_FULL = 2'd2,
      ST_ERR  = 2'd3
   } e_ldState;

   localparam logic [6:0] OPC_LW     = 7'b0000011;
   localparam logic [6:0] OPC_SW     = 7'b0100011;
   localparam logic [6:0] OPC_R_ALU  = 7'b0110011;
   localparam logic [6:0] OPC_B      = 7'b1100011;

   localparam logic [2:0] FUNCT3_WORD = 3'b010;

   localparam int IMM_I_MIN = -2048;
   localparam int IMM_I_MAX = 2047;
   localparam int IMM_B_MIN = -4096;
   localparam int IMM_B_MAX = 4094;

endpackage

// File: rtl/instr_encode.sv
// Combinational RV32I packer: decoded fields in, 32-bit word plus immediate-range flag out.
module instr_encode
   import pa_riscv::*;
(
   input  e_instrKind         i_kind,
   input  logic [4:0]         i_rd,
   input  logic [4:0]         i_rs1,
   input  logic [4:0]         i_rs2,
   input  logic [2:0]         i_funct3,
   input  logic [6:0]         i_funct7,
   input  logic signed [31:0] i_imm,
   output logic [31:0]        o_word,
   output logic               o_immValid
);

   always_comb begin
      o_word     = '0;
      o_immValid = 1'b1;
      case (i_kind)
         LW: begin
            o_word     = {i_imm[11:0], i_rs1, FUNCT3_WORD, i_rd, OPC_LW};
            o_immValid = (i_imm >= IMM_I_MIN) && (i_imm <= IMM_I_MAX);
         end
         SW: begin
            o_word     = {i_imm[11:5], i_rs2, i_rs1, FUNCT3_WORD, i_imm[4:0], OPC_SW};
            o_immValid = (i_imm >= IMM_I_MIN) && (i_imm <= IMM_I_MAX);
         end
         R_TYPE_ALU: begin
            o_word     = {i_funct7, i_rs2, i_rs1, i_funct3, i_rd, OPC_R_ALU};
            o_immValid = 1'b1;
         end
         B_TYPE: begin
            // Branch offsets are halfword multiples; bit 0 is not encodable.
            o_word     = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3,
                          i_imm[4:1], i_imm[11], OPC_B};
            o_immValid = (i_imm >= IMM_B_MIN) && (i_imm <= IMM_B_MAX) && !i_imm[0];
         end
         default: begin
            o_word     = '0;
            o_immValid = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/instr_encoder_loader.sv
// Program loader: encodes field beats and writes them sequentially to instruction memory.
module instr_encoder_loader
   import pa_riscv::*;
#(
   parameter int          DEPTH     = 64,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   localparam int         CW        = $clog2(DEPTH + 1)
)(
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_start,
   input  logic               i_valid,
   output logic               o_ready,
   input  e_instrKind         i_kind,
   input  logic [4:0]         i_rd,
   input  logic [4:0]         i_rs1,
   input  logic [4:0]         i_rs2,
   input  logic [2:0]         i_funct3,
   input  logic [6:0]         i_funct7,
   input  logic signed [31:0] i_imm,
   output logic               o_memWrEn,
   output logic [31:0]        o_memAddr,
   output logic [31:0]        o_memWrData,
   output logic [CW-1:0]      o_count,
   output logic               o_full,
   output logic               o_error,
   output logic [31:0]        o_errorAddr
);

   localparam logic [CW-1:0] LAST_CNT = CW'(DEPTH - 1);

   e_ldState      state_q;
   logic          ready_q;
   logic          wrEn_q;
   logic [31:0]   addr_q;
   logic [31:0]   data_q;
   logic [31:0]   ptr_q;
   logic [CW-1:0] count_q;
   logic          full_q;
   logic          error_q;
   logic [31:0]   errAddr_q;

   logic [31:0]   encWord;
   logic          encImmValid;
   logic          accept_d;

   instr_encode u_encode (
      .i_kind     (i_kind),
      .i_rd       (i_rd),
      .i_rs1      (i_rs1),
      .i_rs2      (i_rs2),
      .i_funct3   (i_funct3),
      .i_funct7   (i_funct7),
      .i_imm      (i_imm),
      .o_word     (encWord),
      .o_immValid (encImmValid)
   );

   // A restart takes priority over any beat presented in the same cycle.
   assign accept_d = ready_q && i_valid && !i_start;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q   <= ST_IDLE;
         ready_q   <= 1'b0;
         wrEn_q    <= 1'b0;
         addr_q    <= BASE_ADDR;
         data_q    <= '0;
         ptr_q     <= BASE_ADDR;
         count_q   <= '0;
         full_q    <= 1'b0;
         error_q   <= 1'b0;
         errAddr_q <= '0;
      end else if (i_start) begin
         state_q <= ST_LOAD;
         ready_q <= 1'b1;
         wrEn_q  <= 1'b0;
         ptr_q   <= BASE_ADDR;
         count_q <= '0;
         full_q  <= 1'b0;
         error_q <= 1'b0;
      end else if (accept_d) begin
         if (encImmValid) begin
            wrEn_q  <= 1'b1;
            addr_q  <= ptr_q;
            data_q  <= encWord;
            ptr_q   <= ptr_q + 32'd4;
            count_q <= count_q + CW'(1);
            if (count_q == LAST_CNT) begin
               state_q <= ST_FULL;
               ready_q <= 1'b0;
               full_q  <= 1'b1;
            end
         end else begin
            // Rejected beat: record where it would have landed, keep pointer and count.
            wrEn_q    <= 1'b0;
            error_q   <= 1'b1;
            errAddr_q <= ptr_q;
            state_q   <= ST_ERR;
            ready_q   <= 1'b0;
         end
      end else begin
         wrEn_q <= 1'b0;
      end
   end

   assign o_ready     = ready_q;
   assign o_memWrEn   = wrEn_q;
   assign o_memAddr   = addr_q;
   assign o_memWrData = data_q;
   assign o_count     = count_q;
   assign o_full      = full_q;
   assign o_error     = error_q;
   assign o_errorAddr = errAddr_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Scoreboard bench for instr_encoder_loader: directed beats, writes checked by a negedge monitor.
module tb_instr_encoder_loader;
   import pa_riscv::*;

   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH + 1);

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
   } wr_t;

   logic               clk;
   logic               rst_n;
   logic               start;
   logic               valid;
   logic               ready;
   e_instrKind         kind;
   logic [4:0]         rd, rs1, rs2;
   logic [2:0]         funct3;
   logic [6:0]         funct7;
   logic signed [31:0] imm;
   logic               wrEn;
   logic [31:0]        memAddr, memData, errAddr;
   logic [CW-1:0]      count;
   logic               full, error;

   wr_t expq[$];
   int  checks   = 0;
   int  failures = 0;

   instr_encoder_loader #(.DEPTH(DEPTH), .BASE_ADDR(32'h0000_0000)) dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_start     (start),
      .i_valid     (valid),
      .o_ready     (ready),
      .i_kind      (kind),
      .i_rd        (rd),
      .i_rs1       (rs1),
      .i_rs2       (rs2),
      .i_funct3    (funct3),
      .i_funct7    (funct7),
      .i_imm       (imm),
      .o_memWrEn   (wrEn),
      .o_memAddr   (memAddr),
      .o_memWrData (memData),
      .o_count     (count),
      .o_full      (full),
      .o_error     (error),
      .o_errorAddr (errAddr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Monitor: every presented write must match the oldest expected write.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && wrEn === 1'b1) begin
         checks++;
         if (expq.size() == 0) begin
            failures++;
            $display("FAIL unexpected_write: got addr 0x%08h data 0x%08h expected none",
                     memAddr, memData);
         end else begin
            wr_t e;
            e = expq.pop_front();
            if (memAddr !== e.addr || memData !== e.data) begin
               failures++;
               $display("FAIL write: got addr 0x%08h data 0x%08h expected addr 0x%08h data 0x%08h",
                        memAddr, memData, e.addr, e.data);
            end
         end
      end
   end

   task automatic do_start();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic set_fields(input e_instrKind k, input logic [4:0] d, input logic [4:0] s1,
                             input logic [4:0] s2, input logic [2:0] f3, input logic [6:0] f7,
                             input logic signed [31:0] im);
      kind = k; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; funct7 = f7; imm = im;
   endtask

   // One accepted beat; a write is expected only when exp_wr is set.
   task automatic beat(input e_instrKind k, input logic [4:0] d, input logic [4:0] s1,
                       input logic [4:0] s2, input logic [2:0] f3, input logic [6:0] f7,
                       input logic signed [31:0] im, input logic exp_wr,
                       input logic [31:0] exp_addr, input logic [31:0] exp_data);
      set_fields(k, d, s1, s2, f3, f7, im);
      if (exp_wr) expq.push_back('{addr: exp_addr, data: exp_data});
      valid = 1'b1;
      @(posedge clk); #1;
      valid = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; valid = 1'b0;
      set_fields(LW, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'sd0);
      #12;
      chk("rst_ready",   {31'd0, ready}, 32'd0);
      chk("rst_wren",    {31'd0, wrEn},  32'd0);
      chk("rst_addr",    memAddr,        32'h0);
      chk("rst_data",    memData,        32'h0);
      chk("rst_count",   32'(count),     32'd0);
      chk("rst_full",    {31'd0, full},  32'd0);
      chk("rst_error",   {31'd0, error}, 32'd0);
      chk("rst_erraddr", errAddr,        32'h0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("idle_ready", {31'd0, ready}, 32'd0);

      // LW x5, 8(x2)
      do_start();
      chk("load_ready", {31'd0, ready}, 32'd1);
      beat(LW, 5'd5, 5'd2, 5'd0, 3'd0, 7'd0, 32'sd8, 1'b1, 32'h0, 32'h0081_2283);
      @(posedge clk); #1;

      // SW x6, 12(x2) then add x7, x5, x6 back-to-back
      do_start();
      beat(SW, 5'd0, 5'd2, 5'd6, 3'd0, 7'd0, 32'sd12, 1'b1, 32'h0, 32'h0061_2623);
      beat(R_TYPE_ALU, 5'd7, 5'd5, 5'd6, 3'd0, 7'd0, 32'sd0, 1'b1, 32'h4, 32'h0062_83B3);
      chk("count_two", 32'(count), 32'd2);

      // beq x4, x4, -8
      beat(B_TYPE, 5'd0, 5'd4, 5'd4, 3'd0, 7'd0, -32'sd8, 1'b1, 32'h8, 32'hFE42_0CE3);
      chk("count_three", 32'(count), 32'd3);

      // Odd branch offset is rejected
      beat(B_TYPE, 5'd0, 5'd4, 5'd4, 3'd0, 7'd0, 32'sd3, 1'b0, 32'h0, 32'h0);
      chk("berr_error",   {31'd0, error}, 32'd1);
      chk("berr_erraddr", errAddr,        32'hC);
      chk("berr_ready",   {31'd0, ready}, 32'd0);
      chk("berr_count",   32'(count),     32'd3);
      @(posedge clk); #1;
      chk("berr_nowrite", {31'd0, wrEn},  32'd0);

      do_start();
      chk("restart_error", {31'd0, error}, 32'd0);
      chk("restart_ready", {31'd0, ready}, 32'd1);
      chk("restart_count", 32'(count),     32'd0);

      // LW immediate just past the 12-bit range
      beat(LW, 5'd1, 5'd1, 5'd0, 3'd0, 7'd0, 32'sd2048, 1'b0, 32'h0, 32'h0);
      chk("lwerr_error",   {31'd0, error}, 32'd1);
      chk("lwerr_erraddr", errAddr,        32'h0);

      // Edge of the LW range is accepted and lands at the base address again
      do_start();
      beat(LW, 5'd1, 5'd3, 5'd0, 3'd0, 7'd0, -32'sd2048, 1'b1, 32'h0, 32'h8001_A083);
      @(posedge clk); #1;

      // Fill: five beats held valid, only DEPTH are taken
      do_start();
      set_fields(R_TYPE_ALU, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 32'sd0);
      for (int i = 0; i < DEPTH; i++)
         expq.push_back('{addr: 32'(i * 4), data: 32'h0031_00B3});
      valid = 1'b1;
      repeat (6) begin
         @(posedge clk); #1;
      end
      valid = 1'b0;
      chk("fill_full",  {31'd0, full},  32'd1);
      chk("fill_ready", {31'd0, ready}, 32'd0);
      chk("fill_count", 32'(count),     32'd4);
      chk("fill_error", {31'd0, error}, 32'd0);
      @(posedge clk); #1;
      chk("fill_queue_drained", 32'(expq.size()), 32'd0);

      // Reset lands while a write is being presented
      do_start();
      set_fields(LW, 5'd5, 5'd2, 5'd0, 3'd0, 7'd0, 32'sd8);
      valid = 1'b1;
      @(posedge clk); #1;
      valid = 1'b0;
      chk("pre_rst_wren", {31'd0, wrEn}, 32'd1);
      #1 rst_n = 1'b0;
      #1;
      chk("midrst_wren",    {31'd0, wrEn},  32'd0);
      chk("midrst_ready",   {31'd0, ready}, 32'd0);
      chk("midrst_addr",    memAddr,        32'h0);
      chk("midrst_data",    memData,        32'h0);
      chk("midrst_count",   32'(count),     32'd0);
      chk("midrst_full",    {31'd0, full},  32'd0);
      chk("midrst_error",   {31'd0, error}, 32'd0);
      chk("midrst_erraddr", errAddr,        32'h0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      valid = 1'b1;
      repeat (2) begin
         @(posedge clk); #1;
      end
      valid = 1'b0;
      chk("post_rst_idle_ready", {31'd0, ready}, 32'd0);
      chk("post_rst_count",      32'(count),     32'd0);
      chk("end_queue_empty",     32'(expq.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
- Instruction encoder plus program loader. It is the inverse of the decode/extend path: it accepts decoded instruction fields (kind, registers, functs, signed immediate) and packs them into 32-bit RV32I words.
- Encoded words are written sequentially into instruction memory from BASE_ADDR.
- Used by the testbench/boot path to fill the single-cycle core's instruction memory. Flags out-of-range immediates.

Parameters:
- DEPTH, 64: number of instruction words the loader may write before reporting full.
- BASE_ADDR, 32'h0000_0000: byte address of the first write; must be 4-byte aligned.

Ports:
- i_clk  input  1  clock.
- i_rst_n  input  1  asynchronous active-low reset.
- i_start  input  1  pulse: (re)start loading at BASE_ADDR; clears error and count.
- i_valid  input  1  field beat valid.
- o_ready  output  1  loader can accept a beat this cycle.
- i_kind  input  2  instruction kind, type e_instrKind: LW, SW, R_TYPE_ALU, B_TYPE.
- i_rd  input  5  destination register.
- i_rs1  input  5  source register 1.
- i_rs2  input  5  source register 2.
- i_funct3  input  3  funct3; R/B kinds only, LW/SW force 3'b010.
- i_funct7  input  7  funct7; R kind only.
- i_imm  input  32  signed byte immediate.
- o_memWrEn  output  1  instruction memory write strobe.
- o_memAddr  output  32  write byte address.
- o_memWrData  output  32  encoded instruction.
- o_count  output  $clog2(DEPTH+1)  words written since start.
- o_full  output  1  DEPTH words written.
- o_error  output  1  sticky: rejected immediate.
- o_errorAddr  output  32  address the rejected beat would have used.

Behaviour:
- Reset (async, i_rst_n=0): state IDLE. o_ready, o_memWrEn, o_full and o_error are 0. o_memAddr = BASE_ADDR. o_memWrData, o_count and o_errorAddr are 0.
- FSM states: IDLE, LOAD, FULL, ERR.
  - IDLE: o_ready=0. i_start moves to LOAD.
  - LOAD: o_ready=1. A beat is accepted when i_valid && o_ready.
  - On the accepted beat that makes count==DEPTH, go to FULL.
  - On an accepted beat whose immediate is invalid, go to ERR.
  - FULL and ERR: o_ready=0. i_start returns to LOAD.
- i_start in any state:
  - next cycle: count=0, write pointer=BASE_ADDR, o_error=0, o_full=0, state LOAD.
  - A beat presented in the same cycle as i_start is ignored, and any pending write in the output register still completes.
- Latency: a beat accepted in cycle N produces o_memWrEn=1 for exactly cycle N+1 (registered). o_memAddr = pointer value and o_memWrData = the encoded word in that cycle.
- Pointer and count:
  - pointer increments by 4 and count by 1 per accepted valid beat.
  - There is no wrap: FULL is reached instead. o_full=1 from cycle N+1 of the DEPTH-th accept.
- Encoding:
  - LW: {imm[11:0], rs1, 3'b010, rd, 7'b0000011}.
  - SW: {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011}.
  - R_TYPE_ALU: {funct7, rs2, rs1, funct3, rd, 7'b0110011}.
  - B_TYPE: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], 7'b1100011}.
- Immediate validity:
  - LW/SW: -2048 to 2047.
  - B_TYPE: -4096 to 4094, and imm[0] must be 0.
  - R kind: i_imm is ignored.
- Error handling: an invalid beat is accepted but not written (o_memWrEn stays 0). o_error=1 and o_errorAddr=pointer from N+1. Pointer and count are unchanged.
- Reset mid-operation: any pending write is dropped (o_memWrEn=0 immediately). All state returns to reset values.

Decomposition:
- Package pa_riscv holds:
  - e_instrKind;
  - opcode constants LW, SW, R_TYPE_ALU, B_TYPE as 7-bit values;
  - FUNCT3_WORD = 3'b010;
  - immediate range constants.
- One combinational sub-module, instr_encode: takes the fields and produces {word, immValid}. The top module holds the FSM, pointer, count and output register.

Test Plan:
- LW rd=5, rs1=2, imm=8 after i_start -> next cycle o_memWrEn=1, addr 0x0, data 0x00812283.
- SW rs2=6, rs1=2, imm=12 then R add (funct7=0, funct3=0) rd=7, rs1=5, rs2=6, back-to-back -> data 0x00612623 at addr 0x0, then 0x006283B3 at addr 0x4; o_count=2.
- B_TYPE funct3=0, rs1=4, rs2=4, imm=-8 -> 0xFE420CE3.
- B_TYPE imm=3 -> no write; o_error=1, o_errorAddr=pointer, o_ready=0. Then i_start -> o_error=0, o_ready=1, addr restarts at BASE_ADDR.
- LW imm=2048 -> error.
- DEPTH=4, 5 valid beats held -> 4 writes at 0x0..0xC, o_full=1, o_ready=0, 5th beat stalled.
- Assert i_rst_n=0 in the cycle after an accept -> o_memWrEn=0 immediately; all outputs at reset values; state IDLE.
